// File: rtl/spio_hss_multiplexer_frame_disassembler_pkg.sv
// Shared constants for the HSS multiplexer frame disassembler: packet/field
// widths, channel count and the K-character codes that open a frame.
package spio_hss_multiplexer_frame_disassembler_pkg;

    localparam int PKT_BITS  = 72;
    localparam int CLR_BITS  = 1;
    localparam int SEQ_BITS  = 8;
    localparam int NUM_CHANS = 8;
    localparam int CHAN_BITS = $clog2(NUM_CHANS);

    localparam logic [7:0] KCH_DFRM = 8'hFC;
    localparam logic [7:0] KCH_OOC  = 8'h7C;

    localparam int HDR_SEQ_LSB = 8;
    localparam int HDR_CLR_LSB = 16;

    // Bit positions of the three packet words inside a 72-bit packet.
    localparam int PKT_HDR_LSB = 0;
    localparam int PKT_KEY_LSB = 8;
    localparam int PKT_PLD_LSB = 40;

endpackage

// File: rtl/spio_hss_multiplexer_next_chan.sv
// Combinational priority encoder: lowest set mask bit above (or, with incl_i,
// at) the current channel, plus a flag when no such bit exists.
module spio_hss_multiplexer_next_chan
    import spio_hss_multiplexer_frame_disassembler_pkg::*;
(
    input  logic [NUM_CHANS-1:0] mask_i,
    input  logic [CHAN_BITS-1:0] cur_i,
    input  logic                 incl_i,
    output logic [CHAN_BITS-1:0] next_o,
    output logic                 last_o
);

    always_comb begin
        next_o = '0;
        last_o = 1'b1;
        // Descending scan so the lowest qualifying channel is the one kept.
        for (int i = NUM_CHANS - 1; i >= 0; i--) begin
            if (mask_i[i] && ((i > int'(cur_i)) || (incl_i && (i == int'(cur_i))))) begin
                next_o = CHAN_BITS'(i);
                last_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/spio_hss_multiplexer_frame_disassembler.sv
// Splits received HSS frames into per-channel packets; packets are held until
// the frame trailer checksum matches, then released together in one cycle.
module spio_hss_multiplexer_frame_disassembler
    import spio_hss_multiplexer_frame_disassembler_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         hsl_data,
    input  logic [3:0]          hsl_kchr,
    input  logic                hsl_vld,
    output logic [PKT_BITS-1:0] ipkt_data0,
    output logic [PKT_BITS-1:0] ipkt_data1,
    output logic [PKT_BITS-1:0] ipkt_data2,
    output logic [PKT_BITS-1:0] ipkt_data3,
    output logic [PKT_BITS-1:0] ipkt_data4,
    output logic [PKT_BITS-1:0] ipkt_data5,
    output logic [PKT_BITS-1:0] ipkt_data6,
    output logic [PKT_BITS-1:0] ipkt_data7,
    output logic                ipkt_vld0,
    output logic                ipkt_vld1,
    output logic                ipkt_vld2,
    output logic                ipkt_vld3,
    output logic                ipkt_vld4,
    output logic                ipkt_vld5,
    output logic                ipkt_vld6,
    output logic                ipkt_vld7,
    output logic [CLR_BITS-1:0] frm_colour,
    output logic [SEQ_BITS-1:0] frm_seq,
    output logic                frm_vld,
    output logic [CLR_BITS-1:0] ooc_colour,
    output logic                ooc_vld
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PKT,
        ST_CHK
    } state_t;

    state_t                state_q;
    logic                  ooc_q;
    logic [NUM_CHANS-1:0]  mask_q;
    logic [SEQ_BITS-1:0]   seq_q;
    logic [CLR_BITS-1:0]   clr_q;
    logic [31:0]           csum_q;
    logic [CHAN_BITS-1:0]  chan_q;
    logic [1:0]            widx_q;

    logic [PKT_BITS-1:0]   hold_q [NUM_CHANS];
    logic [PKT_BITS-1:0]   pkt_q  [NUM_CHANS];
    logic [NUM_CHANS-1:0]  pkt_vld_q;
    logic                  frm_vld_q;
    logic                  ooc_vld_q;
    logic [SEQ_BITS-1:0]   frm_seq_q;
    logic [CLR_BITS-1:0]   frm_clr_q;
    logic [CLR_BITS-1:0]   ooc_clr_q;

    logic                  kword;
    logic                  dword;
    logic                  start_dfrm;
    logic                  start_ooc;
    logic                  in_hdr;
    logic                  trl_ok;
    logic                  commit_frm;
    logic [NUM_CHANS-1:0]  nc_mask;
    logic [CHAN_BITS-1:0]  nc_cur;
    logic [CHAN_BITS-1:0]  chan_d;
    logic                  last_d;

    assign kword      = hsl_vld && (hsl_kchr != 4'h0);
    assign dword      = hsl_vld && (hsl_kchr == 4'h0);
    assign start_dfrm = kword && (hsl_data[7:0] == KCH_DFRM);
    assign start_ooc  = kword && (hsl_data[7:0] == KCH_OOC);
    assign in_hdr     = (state_q == ST_HDR);
    assign trl_ok     = (hsl_data == csum_q);
    assign commit_frm = dword && (state_q == ST_CHK) && !ooc_q && trl_ok;

    // In HDR the first present channel is searched in the incoming mask itself.
    assign nc_mask = in_hdr ? hsl_data[NUM_CHANS-1:0] : mask_q;
    assign nc_cur  = in_hdr ? '0 : chan_q;

    spio_hss_multiplexer_next_chan u_next_chan (
        .mask_i (nc_mask),
        .cur_i  (nc_cur),
        .incl_i (in_hdr),
        .next_o (chan_d),
        .last_o (last_d)
    );

    always_ff @(posedge clk) begin
        frm_vld_q <= 1'b0;
        ooc_vld_q <= 1'b0;
        pkt_vld_q <= '0;
        if (rst) begin
            state_q   <= ST_IDLE;
            ooc_q     <= 1'b0;
            mask_q    <= '0;
            seq_q     <= '0;
            clr_q     <= '0;
            csum_q    <= '0;
            chan_q    <= '0;
            widx_q    <= '0;
            frm_seq_q <= '0;
            frm_clr_q <= '0;
            ooc_clr_q <= '0;
        end else if (kword) begin
            // Any control word ends the frame in progress; a start word opens the next.
            csum_q <= '0;
            chan_q <= '0;
            widx_q <= '0;
            if (start_dfrm || start_ooc) begin
                state_q <= ST_HDR;
                ooc_q   <= start_ooc;
            end else begin
                state_q <= ST_IDLE;
            end
        end else if (dword) begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_HDR: begin
                    csum_q  <= hsl_data;
                    seq_q   <= hsl_data[HDR_SEQ_LSB +: SEQ_BITS];
                    clr_q   <= hsl_data[HDR_CLR_LSB +: CLR_BITS];
                    mask_q  <= ooc_q ? '0 : hsl_data[NUM_CHANS-1:0];
                    chan_q  <= chan_d;
                    widx_q  <= '0;
                    state_q <= (ooc_q || last_d) ? ST_CHK : ST_PKT;
                end
                ST_PKT: begin
                    csum_q <= csum_q ^ hsl_data;
                    if (widx_q == 2'd2) begin
                        widx_q <= '0;
                        chan_q <= chan_d;
                        if (last_d) begin
                            state_q <= ST_CHK;
                        end
                    end else begin
                        widx_q <= widx_q + 2'd1;
                    end
                end
                ST_CHK: begin
                    state_q <= ST_IDLE;
                    if (trl_ok) begin
                        if (ooc_q) begin
                            ooc_vld_q <= 1'b1;
                            ooc_clr_q <= clr_q;
                        end else begin
                            frm_vld_q <= 1'b1;
                            frm_seq_q <= seq_q;
                            frm_clr_q <= clr_q;
                            pkt_vld_q <= mask_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Staging registers: filled word by word, only copied out on a good trailer.
    always_ff @(posedge clk) begin
        if (dword && (state_q == ST_PKT)) begin
            unique case (widx_q)
                2'd0:    hold_q[chan_q][PKT_HDR_LSB +: 8]  <= hsl_data[7:0];
                2'd1:    hold_q[chan_q][PKT_KEY_LSB +: 32] <= hsl_data;
                default: hold_q[chan_q][PKT_PLD_LSB +: 32] <= hsl_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANS; i++) begin
                pkt_q[i] <= '0;
            end
        end else if (commit_frm) begin
            for (int i = 0; i < NUM_CHANS; i++) begin
                if (mask_q[i]) begin
                    pkt_q[i] <= hold_q[i];
                end
            end
        end
    end

    assign ipkt_data0 = pkt_q[0];
    assign ipkt_data1 = pkt_q[1];
    assign ipkt_data2 = pkt_q[2];
    assign ipkt_data3 = pkt_q[3];
    assign ipkt_data4 = pkt_q[4];
    assign ipkt_data5 = pkt_q[5];
    assign ipkt_data6 = pkt_q[6];
    assign ipkt_data7 = pkt_q[7];

    assign ipkt_vld0  = pkt_vld_q[0];
    assign ipkt_vld1  = pkt_vld_q[1];
    assign ipkt_vld2  = pkt_vld_q[2];
    assign ipkt_vld3  = pkt_vld_q[3];
    assign ipkt_vld4  = pkt_vld_q[4];
    assign ipkt_vld5  = pkt_vld_q[5];
    assign ipkt_vld6  = pkt_vld_q[6];
    assign ipkt_vld7  = pkt_vld_q[7];

    assign frm_colour = frm_clr_q;
    assign frm_seq    = frm_seq_q;
    assign frm_vld    = frm_vld_q;
    assign ooc_colour = ooc_clr_q;
    assign ooc_vld    = ooc_vld_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_disassembler.sv
// Bench for the frame disassembler: records the word stream sent and every
// output pulse, and checks pulses against a frame-level reference model.
module tb_spio_hss_multiplexer_frame_disassembler;
    import spio_hss_multiplexer_frame_disassembler_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [31:0]         hsl_data = '0;
    logic [3:0]          hsl_kchr = '0;
    logic                hsl_vld = 1'b0;
    logic [PKT_BITS-1:0] ipkt_data0, ipkt_data1, ipkt_data2, ipkt_data3;
    logic [PKT_BITS-1:0] ipkt_data4, ipkt_data5, ipkt_data6, ipkt_data7;
    logic                ipkt_vld0, ipkt_vld1, ipkt_vld2, ipkt_vld3;
    logic                ipkt_vld4, ipkt_vld5, ipkt_vld6, ipkt_vld7;
    logic [CLR_BITS-1:0] frm_colour, ooc_colour;
    logic [SEQ_BITS-1:0] frm_seq;
    logic                frm_vld, ooc_vld;

    spio_hss_multiplexer_frame_disassembler dut (
        .clk(clk), .rst(rst), .hsl_data(hsl_data), .hsl_kchr(hsl_kchr), .hsl_vld(hsl_vld),
        .ipkt_data0(ipkt_data0), .ipkt_data1(ipkt_data1), .ipkt_data2(ipkt_data2), .ipkt_data3(ipkt_data3),
        .ipkt_data4(ipkt_data4), .ipkt_data5(ipkt_data5), .ipkt_data6(ipkt_data6), .ipkt_data7(ipkt_data7),
        .ipkt_vld0(ipkt_vld0), .ipkt_vld1(ipkt_vld1), .ipkt_vld2(ipkt_vld2), .ipkt_vld3(ipkt_vld3),
        .ipkt_vld4(ipkt_vld4), .ipkt_vld5(ipkt_vld5), .ipkt_vld6(ipkt_vld6), .ipkt_vld7(ipkt_vld7),
        .frm_colour(frm_colour), .frm_seq(frm_seq), .frm_vld(frm_vld),
        .ooc_colour(ooc_colour), .ooc_vld(ooc_vld)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                          frm;
        logic                          ooc;
        logic [SEQ_BITS-1:0]           seq;
        logic [CLR_BITS-1:0]           clr;
        logic [CLR_BITS-1:0]           oclr;
        logic [NUM_CHANS-1:0]          vld;
        logic [NUM_CHANS*PKT_BITS-1:0] data;
    } ev_t;

    typedef struct {
        logic        rst;
        logic        k;
        logic [31:0] d;
        int          c;
    } wd_t;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    wd_t  st[$];
    ev_t  obs_ev[$];
    int   obs_cyc[$];
    ev_t  exp_ev[$];
    int   exp_cyc[$];
    ev_t  hold = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        e.frm  = frm_vld;
        e.ooc  = ooc_vld;
        e.seq  = frm_seq;
        e.clr  = frm_colour;
        e.oclr = ooc_colour;
        e.vld  = {ipkt_vld7, ipkt_vld6, ipkt_vld5, ipkt_vld4, ipkt_vld3, ipkt_vld2, ipkt_vld1, ipkt_vld0};
        e.data = {ipkt_data7, ipkt_data6, ipkt_data5, ipkt_data4, ipkt_data3, ipkt_data2, ipkt_data1, ipkt_data0};
        if ((e.frm | e.ooc | (|e.vld)) === 1'b1) begin
            obs_ev.push_back(e);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic drive(input logic r, input logic v, input logic [3:0] k, input logic [31:0] d);
        wd_t w;
        @(posedge clk);
        #1;
        rst = r; hsl_vld = v; hsl_kchr = k; hsl_data = d;
        w.rst = r; w.k = (k != 4'h0); w.d = d; w.c = cyc + 1;
        if (r || v) st.push_back(w);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'($urandom), $urandom);
    endtask

    // Frame words: header, 3 words per present channel, trailer (XOR ^ flip).
    task automatic send_frame(input bit ooc, input logic [7:0] mask, input logic [7:0] seq,
                              input logic clr, input logic [31:0] flip, input int stop_after,
                              input int stall_before, input int stall_n, input int rst_at,
                              input bit rnd_stall);
        logic [31:0] w[$];
        logic [31:0] hdr, x, r;
        hdr = $urandom;
        hdr[7:0] = mask; hdr[15:8] = seq; hdr[16] = clr;
        w.push_back(hdr);
        x = hdr;
        if (!ooc) begin
            for (int c = 0; c < NUM_CHANS; c++) begin
                if (mask[c]) begin
                    for (int k = 0; k < 3; k++) begin
                        r = $urandom;
                        w.push_back(r);
                        x ^= r;
                    end
                end
            end
        end
        w.push_back(x ^ flip);
        r = $urandom;
        r[7:0] = ooc ? KCH_OOC : KCH_DFRM;
        drive(1'b0, 1'b1, 4'($urandom_range(1, 15)), r);
        for (int i = 0; i < w.size(); i++) begin
            if (stop_after >= 0 && i >= stop_after) break;
            if (i == stall_before) stall(stall_n);
            if (rnd_stall && $urandom_range(0, 5) == 0) stall($urandom_range(1, 3));
            drive(i == rst_at, 1'b1, 4'h0, w[i]);
        end
    endtask

    // Reference: split the stream at control words/resets; a segment opened by a
    // start word yields an event iff its trailer equals the XOR of all prior words.
    task automatic run_model();
        int   i, j, n, p;
        int   body[$];
        bit   ooc;
        logic [7:0]  mask;
        logic [31:0] x, hdr;
        ev_t  e;
        exp_ev.delete();
        exp_cyc.delete();
        i = 0;
        while (i < st.size()) begin
            if (st[i].rst) begin
                hold = '0;
                i++;
                continue;
            end
            if (!st[i].k || !(st[i].d[7:0] == KCH_DFRM || st[i].d[7:0] == KCH_OOC)) begin
                i++;
                continue;
            end
            ooc = (st[i].d[7:0] == KCH_OOC);
            body.delete();
            j = i + 1;
            while (j < st.size() && !st[j].rst && !st[j].k) begin
                body.push_back(j);
                j++;
            end
            if (body.size() >= 1) begin
                hdr  = st[body[0]].d;
                mask = ooc ? 8'h00 : hdr[7:0];
                n    = 1 + 3 * $countones(mask);
                if (body.size() >= n + 1) begin
                    x = 32'h0;
                    for (int k = 0; k < n; k++) x ^= st[body[k]].d;
                    if (x == st[body[n]].d) begin
                        if (ooc) begin
                            hold.oclr = hdr[16 +: CLR_BITS];
                            e = hold;
                            e.ooc = 1'b1;
                        end else begin
                            hold.seq = hdr[15:8];
                            hold.clr = hdr[16 +: CLR_BITS];
                            p = 1;
                            for (int c = 0; c < NUM_CHANS; c++) begin
                                if (mask[c]) begin
                                    hold.data[c*PKT_BITS +: PKT_BITS] =
                                        {st[body[p+2]].d, st[body[p+1]].d, st[body[p]].d[7:0]};
                                    p += 3;
                                end
                            end
                            e = hold;
                            e.frm = 1'b1;
                            e.vld = mask;
                        end
                        exp_ev.push_back(e);
                        exp_cyc.push_back(st[body[n]].c);
                    end
                end
            end
            i = j;
        end
    endtask

    task automatic begin_test();
        st.delete();
        obs_ev.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        begin_test();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (frm_vld !== 1'b0) begin bad++; $display("FAIL reset_frm_vld got=%b want=0", frm_vld); end
        total++; if (ooc_vld !== 1'b0) begin bad++; $display("FAIL reset_ooc_vld got=%b want=0", ooc_vld); end
        total++;
        if ({ipkt_vld7, ipkt_vld6, ipkt_vld5, ipkt_vld4, ipkt_vld3, ipkt_vld2, ipkt_vld1, ipkt_vld0} !== 8'h00) begin
            bad++; $display("FAIL reset_ipkt_vld got=%b%b%b%b%b%b%b%b want=0", ipkt_vld7, ipkt_vld6,
                            ipkt_vld5, ipkt_vld4, ipkt_vld3, ipkt_vld2, ipkt_vld1, ipkt_vld0);
        end
        total++; if (frm_seq !== '0) begin bad++; $display("FAIL reset_frm_seq got=%h want=0", frm_seq); end
        total++; if (frm_colour !== '0) begin bad++; $display("FAIL reset_frm_colour got=%h want=0", frm_colour); end
        total++; if (ooc_colour !== '0) begin bad++; $display("FAIL reset_ooc_colour got=%h want=0", ooc_colour); end
        total++;
        if ({ipkt_data7, ipkt_data6, ipkt_data5, ipkt_data4, ipkt_data3, ipkt_data2, ipkt_data1, ipkt_data0} !== '0) begin
            bad++; $display("FAIL reset_ipkt_data got=%h want=0", ipkt_data0);
        end
        hold = '0;
    endtask

    task automatic test_basic();
        ev_t e0;
        begin_test();
        send_frame(1'b0, 8'h05, 8'h2A, 1'b1, 32'h0, -1, -1, 0, -1, 1'b0);
        stall(4);
        run_model();
        total++;
        if (obs_ev.size() != exp_ev.size()) begin bad++; $display("FAIL basic_count got=%0d want=%0d", obs_ev.size(), exp_ev.size()); end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            total++;
            if (obs_ev[i] !== exp_ev[i] || obs_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL basic_ev%0d got c=%0d %h want c=%0d %h", i, obs_cyc[i], obs_ev[i], exp_cyc[i], exp_ev[i]);
            end
        end
        e0 = (obs_ev.size() > 0) ? obs_ev[0] : '0;
        total++;
        if (e0.frm !== 1'b1 || e0.seq !== 8'h2A || e0.clr !== 1'b1 || e0.vld !== 8'h05 || e0.ooc !== 1'b0) begin
            bad++; $display("FAIL basic_fields got frm=%b seq=%h clr=%b vld=%h ooc=%b want frm=1 seq=2a clr=1 vld=05 ooc=0",
                            e0.frm, e0.seq, e0.clr, e0.vld, e0.ooc);
        end
    endtask

    task automatic test_bad_trailer();
        logic [7:0] s;
        begin_test();
        send_frame(1'b0, 8'h05, 8'h2A, 1'b1, 32'h1, -1, -1, 0, -1, 1'b0);
        s = 8'($urandom);
        send_frame(1'b0, 8'($urandom), s, 1'($urandom), 32'h0, -1, -1, 0, -1, 1'b0);
        stall(4);
        run_model();
        total++;
        if (obs_ev.size() != 1 || exp_ev.size() != 1) begin
            bad++; $display("FAIL badtrl_count got=%0d want=1 (model %0d)", obs_ev.size(), exp_ev.size());
        end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            total++;
            if (obs_ev[i] !== exp_ev[i] || obs_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL badtrl_ev%0d got c=%0d %h want c=%0d %h", i, obs_cyc[i], obs_ev[i], exp_cyc[i], exp_ev[i]);
            end
        end
    endtask

    task automatic test_ooc();
        ev_t e0;
        begin_test();
        send_frame(1'b1, 8'($urandom), 8'($urandom), 1'b0, 32'h0, -1, -1, 0, -1, 1'b0);
        send_frame(1'b1, 8'($urandom), 8'($urandom), 1'b1, 32'h0, -1, -1, 0, -1, 1'b1);
        stall(4);
        run_model();
        total++;
        if (obs_ev.size() != exp_ev.size()) begin bad++; $display("FAIL ooc_count got=%0d want=%0d", obs_ev.size(), exp_ev.size()); end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            total++;
            if (obs_ev[i] !== exp_ev[i] || obs_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL ooc_ev%0d got c=%0d %h want c=%0d %h", i, obs_cyc[i], obs_ev[i], exp_cyc[i], exp_ev[i]);
            end
        end
        e0 = (obs_ev.size() > 0) ? obs_ev[0] : '0;
        total++;
        if (e0.ooc !== 1'b1 || e0.oclr !== 1'b0 || e0.frm !== 1'b0 || e0.vld !== 8'h00) begin
            bad++; $display("FAIL ooc_fields got ooc=%b oclr=%b frm=%b vld=%h want ooc=1 oclr=0 frm=0 vld=00",
                            e0.ooc, e0.oclr, e0.frm, e0.vld);
        end
    endtask

    task automatic test_abort();
        ev_t e0;
        begin_test();
        send_frame(1'b0, 8'($urandom_range(1, 255)), 8'h11, 1'b1, 32'h0, 3, -1, 0, -1, 1'b0);
        send_frame(1'b0, 8'h00, 8'h33, 1'b0, 32'h0, -1, -1, 0, -1, 1'b0);
        // A non-start control word mid-frame drops the frame without restarting.
        send_frame(1'b0, 8'h81, 8'h44, 1'b1, 32'h0, 5, -1, 0, -1, 1'b0);
        drive(1'b0, 1'b1, 4'h2, 32'h0000_00BC);
        drive(1'b0, 1'b1, 4'h0, $urandom);
        stall(4);
        run_model();
        total++;
        if (obs_ev.size() != exp_ev.size()) begin bad++; $display("FAIL abort_count got=%0d want=%0d", obs_ev.size(), exp_ev.size()); end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            total++;
            if (obs_ev[i] !== exp_ev[i] || obs_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL abort_ev%0d got c=%0d %h want c=%0d %h", i, obs_cyc[i], obs_ev[i], exp_cyc[i], exp_ev[i]);
            end
        end
        e0 = (obs_ev.size() > 0) ? obs_ev[0] : '0;
        total++;
        if (obs_ev.size() != 1 || e0.frm !== 1'b1 || e0.seq !== 8'h33 || e0.vld !== 8'h00) begin
            bad++; $display("FAIL abort_fields got n=%0d frm=%b seq=%h vld=%h want n=1 frm=1 seq=33 vld=00",
                            obs_ev.size(), e0.frm, e0.seq, e0.vld);
        end
    endtask

    task automatic test_stall();
        ev_t e0;
        begin_test();
        // Word 15 is channel 4's payload: header, then 3 words each for channels 0..3, then hdr/key.
        send_frame(1'b0, 8'hFF, 8'h5C, 1'b1, 32'h0, -1, 15, 3, -1, 1'b0);
        stall(4);
        run_model();
        total++;
        if (obs_ev.size() != exp_ev.size()) begin bad++; $display("FAIL stall_count got=%0d want=%0d", obs_ev.size(), exp_ev.size()); end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            total++;
            if (obs_ev[i] !== exp_ev[i] || obs_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL stall_ev%0d got c=%0d %h want c=%0d %h", i, obs_cyc[i], obs_ev[i], exp_cyc[i], exp_ev[i]);
            end
        end
        e0 = (obs_ev.size() > 0) ? obs_ev[0] : '0;
        total++;
        if (e0.vld !== 8'hFF) begin bad++; $display("FAIL stall_vld got=%h want=ff", e0.vld); end
    endtask

    task automatic test_reset_mid();
        begin_test();
        // Word 5 is channel 1's key word in a full-mask frame.
        send_frame(1'b0, 8'hFF, 8'h66, 1'b0, 32'h0, -1, -1, 0, 5, 1'b0);
        stall(3);
        send_frame(1'b0, 8'($urandom), 8'h77, 1'b1, 32'h0, -1, -1, 0, -1, 1'b0);
        stall(4);
        run_model();
        total++;
        if (obs_ev.size() != 1 || exp_ev.size() != 1) begin
            bad++; $display("FAIL rstmid_count got=%0d want=1 (model %0d)", obs_ev.size(), exp_ev.size());
        end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            total++;
            if (obs_ev[i] !== exp_ev[i] || obs_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL rstmid_ev%0d got c=%0d %h want c=%0d %h", i, obs_cyc[i], obs_ev[i], exp_cyc[i], exp_ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        begin_test();
        for (int f = 0; f < 4; f++) begin
            send_frame(f == 2, 8'($urandom), 8'($urandom), 1'($urandom), 32'h0, -1, -1, 0, -1, 1'b0);
        end
        stall(4);
        run_model();
        total++;
        if (obs_ev.size() != 4 || exp_ev.size() != 4) begin
            bad++; $display("FAIL b2b_count got=%0d want=4 (model %0d)", obs_ev.size(), exp_ev.size());
        end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            total++;
            if (obs_ev[i] !== exp_ev[i] || obs_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL b2b_ev%0d got c=%0d %h want c=%0d %h", i, obs_cyc[i], obs_ev[i], exp_cyc[i], exp_ev[i]);
            end
        end
    endtask

    task automatic test_random();
        int          r;
        logic [31:0] d;
        logic [31:0] flip;
        int          stop;
        begin_test();
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 14);
            if (r == 0) begin
                d = $urandom;
                if (d[7:0] == KCH_DFRM || d[7:0] == KCH_OOC) d[7:0] = 8'hBC;
                drive(1'b0, 1'b1, 4'($urandom_range(1, 15)), d);
                drive(1'b0, 1'b1, 4'h0, $urandom);
            end else if (r == 1) begin
                drive(1'b1, 1'($urandom), 4'h0, $urandom);
            end else begin
                flip = ($urandom_range(0, 4) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
                stop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : -1;
                send_frame(r == 2 || r == 3, 8'($urandom), 8'($urandom), 1'($urandom),
                           flip, stop, -1, 0, -1, 1'b1);
            end
        end
        stall(4);
        run_model();
        total++;
        if (obs_ev.size() != exp_ev.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_ev.size(), exp_ev.size()); end
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            total++;
            if (obs_ev[i] !== exp_ev[i] || obs_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL rand_ev%0d got c=%0d %h want c=%0d %h", i, obs_cyc[i], obs_ev[i], exp_cyc[i], exp_ev[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_trailer();
        test_ooc();
        test_abort();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spio_hss_multiplexer_frame_disassembler.md
SPIO_HSS_MULTIPLEXER_FRAME_DISASSEMBLER -- requirements
Module: spio_hss_multiplexer_frame_disassembler

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst; these are fixed.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- hsl_data  in  32  received word
- hsl_kchr  in  4  per-byte K-character flags; non-zero marks a control word
- hsl_vld  in  1  word valid; low means stall, with no state change
- ipkt_dataN (N = 0..7)  out  `PKT_BITS  packet for channel N
- ipkt_vldN (N = 0..7)  out  1  packet N valid for one cycle
- frm_colour  out  `CLR_BITS  colour of the accepted data frame
- frm_seq  out  `SEQ_BITS  sequence number of the accepted data frame
- frm_vld  out  1  data frame accepted, one-cycle pulse
- ooc_colour  out  `CLR_BITS  colour of the accepted out-of-credit frame
- ooc_vld  out  1  out-of-credit frame accepted, one-cycle pulse

Function
REQ-003 Frame start SHALL be a control word with hsl_kchr != 0: data[7:0] == `KCH_DFRM starts a data frame; data[7:0] == `KCH_OOC starts an out-of-credit (OOC) frame; any other control word is ignored while in IDLE.
REQ-004 The header word that follows SHALL carry the presence mask in [7:0], seq in [8 +: `SEQ_BITS] and colour in [16 +: `CLR_BITS]; in an OOC header only the colour field is used.
REQ-005 After a data header, each channel whose mask bit is set SHALL supply 3 words, in ascending channel order: hdr (bits [7:0] used), key, payload; these are stored as {payload, key, hdr[7:0]} (72 bits) in a per-channel holding register.
REQ-006 The final word SHALL be a trailer equal to the XOR of the header word and every packet word in the frame; an OOC frame has no packet words, so its trailer equals its header.
REQ-007 The state machine SHALL have the states IDLE, HDR, PKT and CHK:
- IDLE to HDR on a valid start word.
- HDR to PKT if the mask is non-zero, else to CHK.
- PKT steps word index 0..2 and the channel pointer to the next set mask bit; it goes to CHK after word 2 of the highest set channel.
- CHK goes to IDLE.
REQ-008 Any valid word with hsl_kchr != 0 received in HDR, PKT or CHK SHALL abort the frame with no outputs; if that word is itself a valid start word, it SHALL be taken as a new start and the state SHALL go to HDR.
REQ-009 On a matching trailer, the block SHALL in the next cycle pulse frm_vld together with ipkt_vldN for exactly the channels present in the mask; frm_colour, frm_seq and ipkt_dataN SHALL be valid in that cycle.
REQ-010 On a matching OOC trailer, the block SHALL in the next cycle pulse ooc_vld with ooc_colour valid.
REQ-011 On a trailer mismatch, the frame SHALL be discarded silently: no pulses occur and the state returns to IDLE.
REQ-012 No packet SHALL be released before its frame's trailer has been checked; packets from different frames SHALL never be mixed.
REQ-013 Data outputs SHALL hold their last value between pulses; pulse outputs SHALL be low at all other times.
REQ-014 A zero-mask data frame SHALL produce frm_vld with all ipkt_vldN low.
REQ-015 The block SHALL accept one word per cycle, i.e. it has no back-pressure; a new start word SHALL be accepted in the cycle after CHK.

Reset
REQ-016 While rst is high at a clk edge, the state SHALL become IDLE, and the running checksum, channel pointer and word index SHALL be cleared.
REQ-017 While rst is high at a clk edge, all vld and pulse outputs SHALL be cleared to 0, and all data and colour/seq outputs SHALL be cleared to 0.
REQ-018 A reset asserted mid-frame SHALL discard the partial frame, and no pulse SHALL follow the release of reset.

Structure
REQ-019 `PKT_BITS, `CLR_BITS, `SEQ_BITS, `NUM_CHANS, `KCH_DFRM and `KCH_OOC SHALL be defined in the shared spio_hss_multiplexer_common.h.
REQ-020 The state encoding SHALL be local to this module.
REQ-021 The next-set-channel search SHALL be one sub-module, spio_hss_multiplexer_next_chan: a combinational priority encoder taking the mask and current channel and returning the next channel plus a last flag.

Verification
REQ-022 Data frame with mask 8'h05, seq 8'h2A, colour 1, correct trailer -> one cycle after the trailer: frm_vld=1, frm_seq=8'h2A, frm_colour=1, ipkt_vld0=ipkt_vld2=1, all other ipkt_vldN=0, and ipkt_data0/ipkt_data2 equal to the sent words.
REQ-023 The same frame with trailer bit 0 flipped -> no pulse on any output; a following correct frame is accepted normally.
REQ-024 OOC frame with colour 0 -> ooc_vld=1 and ooc_colour=0 one cycle after the trailer; frm_vld stays 0.
REQ-025 Data start, header, 2 packet words, then a new `KCH_DFRM start and a full mask-0 frame -> the first frame is dropped and only frm_vld for the second frame is seen.
REQ-026 Mask 8'hFF frame with hsl_vld low for 3 cycles inside channel 4's payload -> 8 ipkt_vld pulses in the same cycle, with data intact.
REQ-027 rst pulsed during channel 1's key word, then the remaining words of that frame sent -> no outputs, and the block is back in IDLE.
